// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared constants and types for the snake board display path.
// Covers the frame store row type, the idle levels of the outputs and the 7-segment glyphs.
package snake_disp_pkg;

  localparam int         ROWS     = 8;
  localparam logic [7:0] DATA_OFF = 8'hFF;
  localparam logic [3:0] SEL_BASE = 4'b1000;
  localparam logic [1:0] COM_ONES = 2'b01;
  localparam logic [1:0] COM_TENS = 2'b10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_row_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Game-logic/display bundle between the snake core and the matrix scan controller.
// The master side writes rows and requests swaps; the slave side drives the panel pins.
interface matrix_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_r;
  logic [7:0] wr_g;
  logic [7:0] wr_b;
  logic       swap_req;
  logic       swap_ack;
  logic       blank;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic [7:0] DATA_R;
  logic [7:0] DATA_G;
  logic [7:0] DATA_B;
  logic [3:0] SEL;
  logic [7:0] SEG;
  logic [1:0] COM;
  logic       frame_start;

  modport master (
    output wr_en, wr_row, wr_r, wr_g, wr_b, swap_req, blank, digit_tens, digit_ones,
    input  swap_ack, DATA_R, DATA_G, DATA_B, SEL, SEG, COM, frame_start
  );

  modport slave (
    input  wr_en, wr_row, wr_r, wr_g, wr_b, swap_req, blank, digit_tens, digit_ones,
    output swap_ack, DATA_R, DATA_G, DATA_B, SEL, SEG, COM, frame_start
  );
endinterface

// File: rtl/matrix_scan_ctrl_seg.sv
// BCD to 7-segment decode; codes above 9 produce a dark digit.
module bcd_seg_lut
  import snake_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan scheduler for the 8x8 RGB matrix and 2-digit 7-segment display.
// Double-buffered frame store; buffers flip only at the row 7 -> 0 wrap.
module matrix_scan_ctrl
  import snake_disp_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int ROW_HZ = 1000
) (
  input logic               CLK,
  input logic               RST,
  matrix_scan_ctrl_if.slave bus
);

  localparam int               DIV      = CLK_HZ / ROW_HZ;
  localparam int               CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       row;
  logic             front_sel;
  rgb_row_t         frame_mem [2][ROWS];

  logic [7:0] data_r;
  logic [7:0] data_g;
  logic [7:0] data_b;
  logic [3:0] sel;
  logic [7:0] seg;
  logic [1:0] com;
  logic       swap_ack;
  logic       frame_start;

  logic       row_tick;
  logic       boundary;
  logic       swap;
  logic       front_next;
  logic [2:0] row_next;
  logic [1:0] com_next;
  logic [3:0] digit;
  logic [7:0] seg_dec;
  rgb_row_t   wr_data;
  rgb_row_t   show;

  always_comb begin
    row_tick   = (cnt == CNT_LAST);
    row_next   = row + 3'd1;
    boundary   = row_tick && (row == 3'd7);
    swap       = boundary && bus.swap_req;
    front_next = front_sel ^ swap;
    com_next   = {com[0], com[1]};
    digit      = (com_next == COM_TENS) ? bus.digit_tens : bus.digit_ones;
    wr_data    = '{r: bus.wr_r, g: bus.wr_g, b: bus.wr_b};
    show       = frame_mem[front_next][row_next];
    // A write colliding with the swap targets the buffer that becomes front now
    if (swap && bus.wr_en && (bus.wr_row == row_next))
      show = wr_data;
  end

  bcd_seg_lut u_seg (
    .bcd (digit),
    .seg (seg_dec)
  );

  // Scan stage: prescaler, row/digit advance, buffer flip and registered pins
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt         <= '0;
      row         <= 3'd0;
      front_sel   <= 1'b0;
      sel         <= SEL_BASE;
      data_r      <= DATA_OFF;
      data_g      <= DATA_OFF;
      data_b      <= DATA_OFF;
      com         <= COM_ONES;
      seg         <= 8'h00;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < ROWS; i++)
          frame_mem[b][i] <= '0;
    end else begin
      cnt         <= row_tick ? '0 : cnt + CNT_W'(1);
      swap_ack    <= swap;
      frame_start <= boundary;
      if (bus.wr_en)
        frame_mem[~front_sel][bus.wr_row] <= wr_data;
      if (swap)
        front_sel <= ~front_sel;
      if (row_tick) begin
        row    <= row_next;
        com    <= com_next;
        sel    <= {1'b1, row_next};
        data_r <= bus.blank ? DATA_OFF : ~show.r;
        data_g <= bus.blank ? DATA_OFF : ~show.g;
        data_b <= bus.blank ? DATA_OFF : ~show.b;
        seg    <= seg_dec;
      end
    end
  end

  assign bus.DATA_R      = data_r;
  assign bus.DATA_G      = data_g;
  assign bus.DATA_B      = data_b;
  assign bus.SEL         = sel;
  assign bus.SEG         = seg;
  assign bus.COM         = com;
  assign bus.swap_ack    = swap_ack;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl with DIV=4: table-driven digit vectors, directed
// corner sequences and random traffic, all checked against a frame-level model.
module tb_matrix_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_scan_ctrl_if bus ();

  matrix_scan_ctrl #(.CLK_HZ(16), .ROW_HZ(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Model state: two frame buffers, front index, and edge count since reset
  logic [7:0] mr [2][8];
  logic [7:0] mg [2][8];
  logic [7:0] mb [2][8];
  int         m_front;
  int         m_k;
  logic [3:0] m_sel;
  logic [7:0] m_dr, m_dg, m_db, m_seg;
  logic [1:0] m_com;
  logic       m_ack, m_fs;
  logic [7:0] seg_tab [16];

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] seg_tens;
    logic [7:0] seg_ones;
  } seg_vec_t;
  seg_vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  r;
    bit  tick, swp;
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 8; i++) begin
          mr[b][i] = 8'h00; mg[b][i] = 8'h00; mb[b][i] = 8'h00;
        end
      m_front = 0; m_k = 0;
      m_sel = 4'b1000; m_dr = 8'hFF; m_dg = 8'hFF; m_db = 8'hFF;
      m_com = 2'b01; m_seg = 8'h00; m_ack = 1'b0; m_fs = 1'b0;
    end else begin
      m_k++;
      tick = (m_k % 4 == 0);
      r    = (m_k / 4) % 8;
      swp  = tick && (r == 0) && bus.swap_req;
      m_ack = swp;
      m_fs  = tick && (r == 0);
      if (bus.wr_en) begin
        mr[1-m_front][bus.wr_row] = bus.wr_r;
        mg[1-m_front][bus.wr_row] = bus.wr_g;
        mb[1-m_front][bus.wr_row] = bus.wr_b;
      end
      if (swp) m_front = 1 - m_front;
      if (tick) begin
        m_sel = 4'(8 + r);
        m_dr  = bus.blank ? 8'hFF : ~mr[m_front][r];
        m_dg  = bus.blank ? 8'hFF : ~mg[m_front][r];
        m_db  = bus.blank ? 8'hFF : ~mb[m_front][r];
        m_com = (r % 2 == 1) ? 2'b10 : 2'b01;
        m_seg = (r % 2 == 1) ? seg_tab[bus.digit_tens] : seg_tab[bus.digit_ones];
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("sel", bus.SEL, m_sel);
    chk("data_r", bus.DATA_R, m_dr);
    chk("data_g", bus.DATA_G, m_dg);
    chk("data_b", bus.DATA_B, m_db);
    chk("com", bus.COM, m_com);
    chk("seg", bus.SEG, m_seg);
    chk("swap_ack", bus.swap_ack, m_ack);
    chk("frame_start", bus.frame_start, m_fs);
  endtask

  task automatic clear_wr();
    bus.wr_en = 1'b0; bus.wr_row = 3'd0;
    bus.wr_r = 8'h00; bus.wr_g = 8'h00; bus.wr_b = 8'h00;
  endtask

  initial begin
    int  acks;
    bit  got;
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[0] = '{4'd4,  4'd7,  8'h66, 8'h07};
    vecs[1] = '{4'd4,  4'hC,  8'h66, 8'h00};
    vecs[2] = '{4'd0,  4'd1,  8'h3F, 8'h06};
    vecs[3] = '{4'd9,  4'd8,  8'h6F, 8'h7F};
    vecs[4] = '{4'd2,  4'd3,  8'h5B, 8'h4F};
    vecs[5] = '{4'd5,  4'd6,  8'h6D, 8'h7D};
    vecs[6] = '{4'hF,  4'hA,  8'h00, 8'h00};

    clear_wr();
    bus.swap_req = 1'b0; bus.blank = 1'b0;
    bus.digit_tens = 4'd0; bus.digit_ones = 4'd0;

    // Reset held two cycles, then first row tick
    rst = 1'b1;
    step(); step();
    chk("rst_sel", bus.SEL, 4'b1000);
    chk("rst_data_r", bus.DATA_R, 8'hFF);
    chk("rst_data_g", bus.DATA_G, 8'hFF);
    chk("rst_data_b", bus.DATA_B, 8'hFF);
    chk("rst_com", bus.COM, 2'b01);
    chk("rst_seg", bus.SEG, 8'h00);
    chk("rst_ack", bus.swap_ack, 1'b0);
    rst = 1'b0;
    repeat (4) step();
    chk("tick1_sel", bus.SEL, 4'b1001);
    chk("tick1_com", bus.COM, 2'b10);

    // Write row 3 then hold swap_req until acknowledged
    bus.wr_en = 1'b1; bus.wr_row = 3'd3; bus.wr_g = 8'h81;
    step();
    clear_wr();
    bus.swap_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (bus.swap_ack === 1'b1) begin
        got = 1'b1;
        chk("ack_with_frame_start", bus.frame_start, 1'b1);
        chk("ack_at_row0", bus.SEL, 4'b1000);
      end
    end
    chk("swap_ack_seen", got, 1'b1);
    bus.swap_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (m_sel == 4'b1011) begin
        chk("row3_g", bus.DATA_G, 8'h7E);
        chk("row3_r", bus.DATA_R, 8'hFF);
        chk("row3_b", bus.DATA_B, 8'hFF);
      end else begin
        chk("other_g", bus.DATA_G, 8'hFF);
      end
    end

    // Back-buffer write without a swap stays invisible
    bus.wr_en = 1'b1; bus.wr_row = 3'd5; bus.wr_g = 8'h0F;
    step();
    clear_wr();
    acks = 0;
    for (int i = 0; i < 96; i++) begin
      step();
      if (bus.swap_ack === 1'b1) acks++;
      if (m_sel == 4'b1101) chk("row5_untorn", bus.DATA_G, 8'hFF);
    end
    chk("no_ack_tearfree", acks, 0);

    // Write lands in the same cycle as the swap
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if ((m_k % 4 == 3) && (((m_k + 1) / 4) % 8 == 0)) got = 1'b1;
      else step();
    end
    chk("reach_swap_cycle", got, 1'b1);
    bus.swap_req = 1'b1;
    bus.wr_en = 1'b1; bus.wr_row = 3'd0; bus.wr_r = 8'hFF;
    step();
    clear_wr();
    bus.swap_req = 1'b0;
    chk("collide_ack", bus.swap_ack, 1'b1);
    chk("collide_sel", bus.SEL, 4'b1000);
    chk("collide_r", bus.DATA_R, 8'h00);
    for (int i = 0; i < 32; i++) begin
      step();
      if (m_sel == 4'b1000) chk("collide_r_next", bus.DATA_R, 8'h00);
    end

    // Digit table
    for (int v = 0; v < 7; v++) begin
      bus.digit_tens = vecs[v].tens;
      bus.digit_ones = vecs[v].ones;
      for (int h = 0; h < 2; h++) begin
        repeat (4) step();
        chk("seg_vec", bus.SEG, (m_com == 2'b01) ? vecs[v].seg_ones : vecs[v].seg_tens);
      end
    end

    // Blank keeps scanning with dark pixels
    bus.blank = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 36; i++) begin
      step();
      chk("blank_r", bus.DATA_R, 8'hFF);
      chk("blank_g", bus.DATA_G, 8'hFF);
    end
    bus.blank = 1'b0;

    // Reset at row 6 with a pending request drops the swap
    bus.swap_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (m_sel == 4'b1110) got = 1'b1;
    end
    chk("reach_row6", got, 1'b1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    bus.swap_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.swap_ack === 1'b1) acks++;
      chk("cleared_r", bus.DATA_R, 8'hFF);
    end
    chk("no_ack_after_rst", acks, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bus.wr_en      = ($urandom_range(0, 2) == 0);
      bus.wr_row     = 3'($urandom_range(0, 7));
      bus.wr_r       = 8'($urandom);
      bus.wr_g       = 8'($urandom);
      bus.wr_b       = 8'($urandom);
      bus.swap_req   = ($urandom_range(0, 7) == 0);
      bus.blank      = ($urandom_range(0, 15) == 0);
      bus.digit_tens = 4'($urandom);
      bus.digit_ones = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
